ex_stage_mc: RTL and testbench

- Parametrised successor to the single-cycle execute stage. Contains the ALU, the ALU control decode, the destination-register mux, the branch-target adder and the registered EX/MEM pipeline register.
- Adds three things: a multi-cycle iterative unsigned multiplier with HI/LO registers, a valid/ready stall handshake, and optional operand forwarding.
- Sits between the ID/EX register and the MEM stage.

---
 rtl/ex_pkg.sv | 61 ++++++
 rtl/ex_stage_mc_if.sv | 53 +++++
 rtl/ex_mul_seq.sv | 78 +++++++
 rtl/ex_stage_mc.sv | 119 +++++++++++
 tb/tb_ex_stage_mc.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the multi-cycle execute stage: ALU functions,
// ALU-op and funct encodings, multiplier FSM states and the ALU decode helper.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_PASS_HI,
    ALU_PASS_LO,
    ALU_MUL
  } alu_fn_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  // Unknown funct codes fall back to add.
  function automatic alu_fn_e decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_fn_e fn;
    fn = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: fn = ALU_ADD;
      ALUOP_SUB: fn = ALU_SUB;
      ALUOP_OR:  fn = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:   fn = ALU_ADD;
          FN_SUB:   fn = ALU_SUB;
          FN_AND:   fn = ALU_AND;
          FN_OR:    fn = ALU_OR;
          FN_SLT:   fn = ALU_SLT;
          FN_MULTU: fn = ALU_MUL;
          FN_MFHI:  fn = ALU_PASS_HI;
          FN_MFLO:  fn = ALU_PASS_LO;
          default:  fn = ALU_ADD;
        endcase
      end
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ex_stage_mc_if.sv
// ID/EX-to-EX/MEM bundle for ex_stage_mc: issue handshake, operands, forwarding
// taps and the registered EX/MEM outputs.
interface ex_stage_mc_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              in_valid;
  logic              ex_ready;
  logic              mem_stall;
  logic [1:0]        ctlwb_in;
  logic [2:0]        ctlm_in;
  logic [1:0]        alu_op;
  logic              reg_dst;
  logic              alu_src;
  logic [REG_W-1:0]  rs_idx;
  logic [REG_W-1:0]  rt_idx;
  logic [REG_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] npc;
  logic              fwd_mem_we;
  logic [REG_W-1:0]  fwd_mem_idx;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_wb_we;
  logic [REG_W-1:0]  fwd_wb_idx;
  logic [DATA_W-1:0] fwd_wb_data;
  logic              out_valid;
  logic [1:0]        wb_ctlout;
  logic [2:0]        m_ctlout;
  logic [DATA_W-1:0] add_result;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rdata2out;
  logic              zero;
  logic [REG_W-1:0]  dest_idx;
  logic              mul_busy;

  modport master (
    output in_valid, mem_stall, ctlwb_in, ctlm_in, alu_op, reg_dst, alu_src,
           rs_idx, rt_idx, rd_idx, rs_data, rt_data, imm, npc,
           fwd_mem_we, fwd_mem_idx, fwd_mem_data, fwd_wb_we, fwd_wb_idx, fwd_wb_data,
    input  ex_ready, out_valid, wb_ctlout, m_ctlout, add_result, alu_result,
           rdata2out, zero, dest_idx, mul_busy
  );

  modport slave (
    input  in_valid, mem_stall, ctlwb_in, ctlm_in, alu_op, reg_dst, alu_src,
           rs_idx, rt_idx, rd_idx, rs_data, rt_data, imm, npc,
           fwd_mem_we, fwd_mem_idx, fwd_mem_data, fwd_wb_we, fwd_wb_idx, fwd_wb_data,
    output ex_ready, out_valid, wb_ctlout, m_ctlout, add_result, alu_result,
           rdata2out, zero, dest_idx, mul_busy
  );
endinterface

// File: rtl/ex_mul_seq.sv
// Iterative shift-add unsigned multiplier with its IDLE/BUSY/DONE FSM and the
// HI/LO result registers; one multiplier bit is retired per BUSY cycle.
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(MUL_CYCLES + 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] mcand_q;
  logic [PROD_W-1:0] acc_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: a reset mid-multiply discards the partial product along with HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= PROD_W'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        DONE: {hi_q, lo_q} <= acc_q;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: ALU, branch-target adder, iterative multiplier and
// EX/MEM register with stall handshake. Operand forwarding under EX_STAGE_FWD_EN.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MUL_CYCLES = DATA_W
) (
  input logic         clk,
  input logic         reset,
  ex_stage_mc_if.slave bus
);
  logic [DATA_W-1:0] rs_val, rt_val, op_b, alu_res, hi, lo;
  logic              mul_busy_int, accept, is_mul, load;
  alu_fn_e           alu_fn;

  logic              valid_q;
  logic [1:0]        wb_q;
  logic [2:0]        m_q;
  logic [DATA_W-1:0] add_q, alu_q, rd2_q;
  logic              zero_q;
  logic [REG_W-1:0]  dest_q;

`ifdef EX_STAGE_FWD_EN
  // MEM beats WB beats register file; register 0 never forwards.
  always_comb begin
    rs_val = bus.rs_data;
    if (bus.fwd_mem_we && bus.fwd_mem_idx == bus.rs_idx && bus.rs_idx != '0)
      rs_val = bus.fwd_mem_data;
    else if (bus.fwd_wb_we && bus.fwd_wb_idx == bus.rs_idx && bus.rs_idx != '0)
      rs_val = bus.fwd_wb_data;
  end

  always_comb begin
    rt_val = bus.rt_data;
    if (bus.fwd_mem_we && bus.fwd_mem_idx == bus.rt_idx && bus.rt_idx != '0)
      rt_val = bus.fwd_mem_data;
    else if (bus.fwd_wb_we && bus.fwd_wb_idx == bus.rt_idx && bus.rt_idx != '0)
      rt_val = bus.fwd_wb_data;
  end
`else
  logic unused_fwd;
  assign rs_val     = bus.rs_data;
  assign rt_val     = bus.rt_data;
  assign unused_fwd = ^{bus.fwd_mem_we, bus.fwd_mem_idx, bus.fwd_mem_data,
                        bus.fwd_wb_we, bus.fwd_wb_idx, bus.fwd_wb_data, bus.rs_idx};
`endif

  assign op_b   = bus.alu_src ? bus.imm : rt_val;
  assign alu_fn = decode_alu(bus.alu_op, bus.imm[5:0]);
  assign is_mul = (alu_fn == ALU_MUL);

  assign bus.ex_ready = !bus.mem_stall && !mul_busy_int;
  assign accept       = bus.in_valid && bus.ex_ready;
  assign load         = accept && !is_mul;

  always_comb begin
    alu_res = rs_val + op_b;
    case (alu_fn)
      ALU_ADD:     alu_res = rs_val + op_b;
      ALU_SUB:     alu_res = rs_val - op_b;
      ALU_AND:     alu_res = rs_val & op_b;
      ALU_OR:      alu_res = rs_val | op_b;
      ALU_SLT:     alu_res = DATA_W'($signed(rs_val) < $signed(op_b));
      ALU_PASS_HI: alu_res = hi;
      ALU_PASS_LO: alu_res = lo;
      default:     alu_res = rs_val + op_b;
    endcase
  end

  ex_mul_seq #(
    .DATA_W    (DATA_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(accept && is_mul),
    .a    (rs_val),
    .b    (rt_val),
    .busy (mul_busy_int),
    .hi   (hi),
    .lo   (lo)
  );

  // EX/MEM register: holds under mem_stall, otherwise loads an instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      m_q     <= '0;
      add_q   <= '0;
      alu_q   <= '0;
      rd2_q   <= '0;
      zero_q  <= 1'b0;
      dest_q  <= '0;
    end else if (!bus.mem_stall) begin
      valid_q <= load;
      wb_q    <= load ? bus.ctlwb_in : 2'b00;
      m_q     <= load ? bus.ctlm_in : 3'b000;
      add_q   <= bus.npc + (bus.imm << 2);
      alu_q   <= alu_res;
      rd2_q   <= rt_val;
      zero_q  <= (alu_res == '0);
      dest_q  <= bus.reg_dst ? bus.rd_idx : bus.rt_idx;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.wb_ctlout  = wb_q;
  assign bus.m_ctlout   = m_q;
  assign bus.add_result = add_q;
  assign bus.alu_result = alu_q;
  assign bus.rdata2out  = rd2_q;
  assign bus.zero       = zero_q;
  assign bus.dest_idx   = dest_q;
  assign bus.mul_busy   = mul_busy_int;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: directed cases then random traffic against a
// behavioural model; a separate monitor checks every EX/MEM load, hold and reset.
module tb_ex_stage_mc;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned MC = 32;
`ifdef EX_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_mc_if #(.DATA_W(DW), .REG_W(RW)) bus ();
  ex_stage_mc #(.DATA_W(DW), .REG_W(RW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  ctlwb;
    logic [2:0]  ctlm;
    logic [1:0]  op;
    logic        reg_dst, alu_src;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm, npc;
    logic        mwe;
    logic [4:0]  midx;
    logic [31:0] mdat;
    logic        wwe;
    logic [4:0]  widx;
    logic [31:0] wdat;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add, alu, rd2;
    logic        zero;
    logic [4:0]  dest;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          vectors = 0;
  int          errors  = 0;
  int          stall_left = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic [63:0] pend = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
    if (FWD && s.mwe && s.midx == idx && idx != 5'd0) return s.mdat;
    if (FWD && s.wwe && s.widx == idx && idx != 5'd0) return s.wdat;
    return rf;
  endfunction

  function automatic logic [31:0] alu_model(input stim_t s, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] fn;
    fn = s.imm[5:0];
    if (s.op == 2'd1) return a - b;
    if (s.op == 2'd3) return a | b;
    if (s.op == 2'd0) return a + b;
    case (fn)
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h10:   return hi_m;
      6'h12:   return lo_m;
      default: return a + b;
    endcase
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{valid: 1'b0, ctlwb: 2'd0, ctlm: 3'd0, op: 2'd0, reg_dst: 1'b0, alu_src: 1'b0,
          rs: 5'd0, rt: 5'd0, rd: 5'd0, rs_d: '0, rt_d: '0, imm: '0, npc: '0,
          mwe: 1'b0, midx: 5'd0, mdat: '0, wwe: 1'b0, widx: 5'd0, wdat: '0};
    return s;
  endfunction

  function automatic stim_t rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = nop();
    s.valid = 1'b1; s.op = 2'd2; s.imm = {26'h0, fn}; s.rs_d = a; s.rt_d = b;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd9; s.reg_dst = 1'b1; s.ctlwb = 2'b10; s.ctlm = 3'b001;
    s.npc = 32'h40;
    return s;
  endfunction

  // One clock of stimulus: drive, check the handshake, predict EX/MEM, advance the model.
  task automatic apply(input stim_t s, input logic rst, input logic stall, output logic accepted);
    logic        ready_exp, mul;
    logic [31:0] a, rt, b;
    exp_t        e;
    reset            = rst;
    bus.mem_stall    = stall;
    bus.in_valid     = s.valid;
    bus.ctlwb_in     = s.ctlwb;
    bus.ctlm_in      = s.ctlm;
    bus.alu_op       = s.op;
    bus.reg_dst      = s.reg_dst;
    bus.alu_src      = s.alu_src;
    bus.rs_idx       = s.rs;
    bus.rt_idx       = s.rt;
    bus.rd_idx       = s.rd;
    bus.rs_data      = s.rs_d;
    bus.rt_data      = s.rt_d;
    bus.imm          = s.imm;
    bus.npc          = s.npc;
    bus.fwd_mem_we   = s.mwe;
    bus.fwd_mem_idx  = s.midx;
    bus.fwd_mem_data = s.mdat;
    bus.fwd_wb_we    = s.wwe;
    bus.fwd_wb_idx   = s.widx;
    bus.fwd_wb_data  = s.wdat;
    #3;
    ready_exp = !stall && stall_left == 0;
    chk("ex_ready", 32'(bus.ex_ready), 32'(ready_exp));
    chk("mul_busy", 32'(bus.mul_busy), 32'(stall_left > 0));
    accepted = !rst && s.valid && ready_exp;
    a   = fwd_val(s.rs, s.rs_d, s);
    rt  = fwd_val(s.rt, s.rt_d, s);
    b   = s.alu_src ? s.imm : rt;
    mul = (s.op == 2'd2) && (s.imm[5:0] == 6'h19);
    if (!rst && !stall) begin
      e.valid = accepted && !mul;
      e.wb    = e.valid ? s.ctlwb : 2'd0;
      e.m     = e.valid ? s.ctlm : 3'd0;
      e.add   = s.npc + (s.imm << 2);
      e.alu   = alu_model(s, a, b);
      e.rd2   = rt;
      e.zero  = (e.alu == 32'd0);
      e.dest  = s.reg_dst ? s.rd : s.rt;
      sb.push_back(e);
    end
    if (rst) begin
      stall_left = 0; hi_m = '0; lo_m = '0;
    end else begin
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) {hi_m, lo_m} = pend;
      end
      if (accepted && mul) begin
        stall_left = MC + 1;
        pend = {32'd0, a} * {32'd0, rt};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input stim_t s);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      apply(s, 1'b0, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      vectors++; errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) apply(nop(), 1'b0, 1'b0, acc);
  endtask

  task automatic cmp_out(input exp_t e, input bit full);
    chk("out_valid", 32'(bus.out_valid), 32'(e.valid));
    chk("wb_ctlout", 32'(bus.wb_ctlout), 32'(e.wb));
    chk("m_ctlout", 32'(bus.m_ctlout), 32'(e.m));
    if (full || e.valid) begin
      chk("add_result", bus.add_result, e.add);
      chk("alu_result", bus.alu_result, e.alu);
      chk("rdata2out", bus.rdata2out, e.rd2);
      chk("zero", 32'(bus.zero), 32'(e.zero));
      chk("dest_idx", 32'(bus.dest_idx), 32'(e.dest));
    end
  endtask

  // Monitor: classify each clock edge from the inputs that were present at it.
  initial begin
    logic r, st;
    exp_t e;
    forever begin
      @(posedge clk);
      r  = reset;
      st = bus.mem_stall;
      @(negedge clk);
      if (r) begin
        e = '{valid: 1'b0, wb: 2'd0, m: 3'd0, add: '0, alu: '0, rd2: '0, zero: 1'b0, dest: 5'd0};
        cmp_out(e, 1'b1);
        last_exp = e;
      end else if (st) begin
        cmp_out(last_exp, 1'b0);
      end else if (sb.size() == 0) begin
        vectors++; errors++;
        $display("FAIL scoreboard_underflow: got EX/MEM load expected a queued entry");
      end else begin
        e = sb.pop_front();
        cmp_out(e, 1'b0);
        last_exp = e;
      end
    end
  end

  initial begin
    stim_t s;
    logic  acc;
    logic [5:0] fns [9];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h19, 6'h3F};

    apply(nop(), 1'b1, 1'b0, acc);
    apply(nop(), 1'b1, 1'b0, acc);

    issue(rtype(6'h20, 32'd7, 32'd5));

    s = rtype(6'h00, 32'h1234, 32'h1234);
    s.op = 2'd1; s.npc = 32'h100; s.imm = 32'd3;
    issue(s);

    issue(rtype(6'h19, 32'hFFFF_FFFF, 32'd2));
    issue(rtype(6'h10, 32'd0, 32'd0));
    issue(rtype(6'h12, 32'd0, 32'd0));

    issue(rtype(6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF));
    s = rtype(6'h25, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) apply(s, 1'b0, 1'b1, acc);
    issue(s);
    issue(rtype(6'h2A, 32'hFFFF_FFFE, 32'd1));

    s = rtype(6'h20, 32'd1, 32'd0);
    s.rs = 5'd3; s.rt = 5'd0;
    s.mwe = 1'b1; s.midx = 5'd3; s.mdat = 32'd40;
    s.wwe = 1'b1; s.widx = 5'd3; s.wdat = 32'd99;
    issue(s);
    s.rs = 5'd0; s.midx = 5'd0; s.widx = 5'd0;
    issue(s);

    issue(rtype(6'h19, 32'd123, 32'd456));
    idle(9);
    apply(nop(), 1'b1, 1'b0, acc);
    issue(rtype(6'h10, 32'd0, 32'd0));
    issue(rtype(6'h12, 32'd0, 32'd0));

    for (int i = 0; i < 500; i++) begin
      s = nop();
      s.valid   = ($urandom_range(0, 4) != 0);
      s.ctlwb   = 2'($urandom);
      s.ctlm    = 3'($urandom);
      s.op      = 2'($urandom);
      s.reg_dst = 1'($urandom);
      s.alu_src = ($urandom_range(0, 3) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom);
      s.rs_d    = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      s.rt_d    = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      s.npc     = $urandom;
      s.imm     = $urandom;
      s.imm[5:0] = fns[$urandom_range(0, 8)];
      if (s.imm[5:0] == 6'h19 && $urandom_range(0, 3) != 0) s.imm[5:0] = 6'h20;
      s.mwe  = 1'($urandom); s.midx = 5'($urandom_range(0, 3)); s.mdat = $urandom;
      s.wwe  = 1'($urandom); s.widx = 5'($urandom_range(0, 3)); s.wdat = $urandom;
      apply(s, ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), acc);
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
